// File: rtl/compute_src_gcid_tx_pkg.sv
// Shared widths, fold geometry and transmit FSM encoding for the
// outbound global-cell-ID tagging path.
package compute_src_gcid_tx_pkg;

    localparam int unsigned GLOBAL_CELL_ID_WIDTH = 3;
    localparam int unsigned CELL_FOLD_ID_WIDTH   = 2;
    localparam int unsigned NUM_CELL_FOLDS       = 2;

    typedef logic [GLOBAL_CELL_ID_WIDTH-1:0] gcid_t;
    typedef logic [CELL_FOLD_ID_WIDTH-1:0]   fold_id_t;

    typedef struct packed {
        gcid_t x;
        gcid_t y;
        gcid_t z;
    } gcid_xyz_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } tx_state_t;

endpackage

// File: rtl/compute_src_gcid_tx_if.sv
// Record-in / framed-beat-out handshake bundle for compute_src_gcid_tx.
interface compute_src_gcid_tx_if #(
    parameter int unsigned DATA_WIDTH = 96,
    parameter int unsigned CNT_WIDTH  = 8
) ();
    import compute_src_gcid_tx_pkg::*;

    logic                  i_valid;
    logic                  o_ready;
    fold_id_t              i_fold_id;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_last;

    logic                  o_valid;
    logic                  i_ready;
    logic                  o_is_hdr;
    gcid_t                 o_gcid_x;
    gcid_t                 o_gcid_y;
    gcid_t                 o_gcid_z;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_last;
    logic [CNT_WIDTH-1:0]  o_burst_cnt;
    logic                  o_fold_err;

    modport master (
        output i_valid, i_fold_id, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_is_hdr, o_gcid_x, o_gcid_y, o_gcid_z,
               o_data, o_last, o_burst_cnt, o_fold_err
    );

    modport slave (
        input  i_valid, i_fold_id, i_data, i_last, i_ready,
        output o_ready, o_valid, o_is_hdr, o_gcid_x, o_gcid_y, o_gcid_z,
               o_data, o_last, o_burst_cnt, o_fold_err
    );

endinterface

// File: rtl/compute_src_gcid_tx_src_gcid_lookup.sv
// Combinational fold -> global (x,y,z) cell ID lookup with range check;
// out-of-range folds map to (0,0,0).
module src_gcid_lookup
    import compute_src_gcid_tx_pkg::*;
#(
    parameter gcid_t GCELL_X [NUM_CELL_FOLDS] = '{default: '0},
    parameter gcid_t GCELL_Y [NUM_CELL_FOLDS] = '{default: '0},
    parameter gcid_t GCELL_Z [NUM_CELL_FOLDS] = '{default: '0}
) (
    input  fold_id_t  fold_id,
    output gcid_xyz_t gcid,
    output logic      in_range
);

    always_comb begin
        gcid     = '0;
        in_range = 1'b0;
        // Compare-and-select avoids indexing a NUM_CELL_FOLDS array with a wider fold ID
        for (int unsigned i = 0; i < NUM_CELL_FOLDS; i++) begin
            if (32'(fold_id) == i) begin
                gcid.x   = GCELL_X[i];
                gcid.y   = GCELL_Y[i];
                gcid.z   = GCELL_Z[i];
                in_range = 1'b1;
            end
        end
    end

endmodule

// File: rtl/compute_src_gcid_tx.sv
// Tags a burst of particle records from one local fold with that fold's
// global cell ID and emits header + data beats with a final particle count.
module compute_src_gcid_tx
    import compute_src_gcid_tx_pkg::*;
#(
    parameter gcid_t       GCELL_X [NUM_CELL_FOLDS] = '{default: '0},
    parameter gcid_t       GCELL_Y [NUM_CELL_FOLDS] = '{default: '0},
    parameter gcid_t       GCELL_Z [NUM_CELL_FOLDS] = '{default: '0},
    parameter int unsigned DATA_WIDTH = 96,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    compute_src_gcid_tx_if.slave bus
);

    tx_state_t             state_q, state_d;
    logic                  o_valid_q, o_valid_d;
    logic                  o_is_hdr_q, o_is_hdr_d;
    gcid_xyz_t             gcid_q, gcid_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic                  o_last_q, o_last_d;
    logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;
    logic                  fold_err_q, fold_err_d;

    gcid_xyz_t lut_gcid;
    logic      lut_in_range;
    logic      slot_free;
    logic      o_ready;

    src_gcid_lookup #(
        .GCELL_X (GCELL_X),
        .GCELL_Y (GCELL_Y),
        .GCELL_Z (GCELL_Z)
    ) u_lookup (
        .fold_id  (bus.i_fold_id),
        .gcid     (lut_gcid),
        .in_range (lut_in_range)
    );

    // gcid_q doubles as the latched fold: it is only written at header load,
    // so later i_fold_id changes within the burst cannot reach the output.
    always_comb begin
        state_d     = state_q;
        o_valid_d   = o_valid_q;
        o_is_hdr_d  = o_is_hdr_q;
        gcid_d      = gcid_q;
        o_data_d    = o_data_q;
        o_last_d    = o_last_q;
        burst_cnt_d = burst_cnt_q;
        fold_err_d  = fold_err_q;

        slot_free = !o_valid_q || bus.i_ready;
        o_ready   = (state_q == BODY) && slot_free;

        if (bus.i_ready) begin
            o_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.i_valid && slot_free) begin
                    state_d     = HDR;
                    o_valid_d   = 1'b1;
                    o_is_hdr_d  = 1'b1;
                    gcid_d      = lut_gcid;
                    o_data_d    = '0;
                    o_last_d    = 1'b0;
                    burst_cnt_d = '0;
                    if (!lut_in_range) begin
                        fold_err_d = 1'b1;
                    end
                end
            end
            HDR: begin
                state_d = BODY;
            end
            BODY: begin
                if (bus.i_valid && o_ready) begin
                    o_valid_d   = 1'b1;
                    o_is_hdr_d  = 1'b0;
                    o_data_d    = bus.i_data;
                    o_last_d    = bus.i_last;
                    burst_cnt_d = (burst_cnt_q == '1) ? burst_cnt_q : burst_cnt_q + 1'b1;
                    if (bus.i_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            o_valid_q   <= 1'b0;
            o_is_hdr_q  <= 1'b0;
            gcid_q      <= '0;
            o_data_q    <= '0;
            o_last_q    <= 1'b0;
            burst_cnt_q <= '0;
            fold_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_valid_q   <= o_valid_d;
            o_is_hdr_q  <= o_is_hdr_d;
            gcid_q      <= gcid_d;
            o_data_q    <= o_data_d;
            o_last_q    <= o_last_d;
            burst_cnt_q <= burst_cnt_d;
            fold_err_q  <= fold_err_d;
        end
    end

    assign bus.o_ready     = o_ready;
    assign bus.o_valid     = o_valid_q;
    assign bus.o_is_hdr    = o_is_hdr_q;
    assign bus.o_gcid_x    = gcid_q.x;
    assign bus.o_gcid_y    = gcid_q.y;
    assign bus.o_gcid_z    = gcid_q.z;
    assign bus.o_data      = o_data_q;
    assign bus.o_last      = o_last_q;
    assign bus.o_burst_cnt = burst_cnt_q;
    assign bus.o_fold_err  = fold_err_q;

endmodule

// File: tb/tb_compute_src_gcid_tx.sv
// Randomized bench for compute_src_gcid_tx: frames predicted from burst
// descriptions, compared beat by beat as they are accepted downstream.
module tb_compute_src_gcid_tx;
    import compute_src_gcid_tx_pkg::*;

    localparam int unsigned DW = 96;
    localparam int unsigned CW = 8;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    compute_src_gcid_tx_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    compute_src_gcid_tx #(
        .GCELL_X    ('{3'd1, 3'd2}),
        .GCELL_Y    ('{3'd0, 3'd3}),
        .GCELL_Z    ('{3'd4, 3'd5}),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        bit            hdr;
        logic [8:0]    gcid;
        logic [DW-1:0] data;
        bit            last;
        int unsigned   cnt;
        bit            err;
    } beat_t;

    logic [2:0] ref_x [2] = '{3'd1, 3'd2};
    logic [2:0] ref_y [2] = '{3'd0, 3'd3};
    logic [2:0] ref_z [2] = '{3'd4, 3'd5};

    beat_t       exp_q[$];
    bit          err_model = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned ready_pct = 100;
    int          stall_left = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Downstream ready: forced stalls first, otherwise random with ready_pct.
    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.i_ready = 1'b0;
                stall_left--;
            end else begin
                bus.i_ready = ($urandom_range(99) < ready_pct);
            end
        end
    end

    // Monitor: hold check, ready check and scoreboard at the falling edge.
    logic [116:0] snap_prev;
    bit           stall_prev = 1'b0;
    beat_t        e;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check_eq("hold_stable", 128'({bus.o_valid, bus.o_is_hdr, bus.o_gcid_x, bus.o_gcid_y,
                         bus.o_gcid_z, bus.o_data, bus.o_last, bus.o_burst_cnt, bus.o_fold_err}),
                         128'(snap_prev));
            if (bus.o_valid && !bus.i_ready)
                check_eq("o_ready_when_stalled", 128'(bus.o_ready), 128'(0));
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("is_hdr", 128'(bus.o_is_hdr), 128'(e.hdr));
                    check_eq("gcid", 128'({bus.o_gcid_x, bus.o_gcid_y, bus.o_gcid_z}), 128'(e.gcid));
                    check_eq("data", 128'(bus.o_data), 128'(e.data));
                    check_eq("last", 128'(bus.o_last), 128'(e.last));
                    if (e.last)
                        check_eq("burst_cnt", 128'(bus.o_burst_cnt), 128'(e.cnt));
                    check_eq("fold_err", 128'(bus.o_fold_err), 128'(e.err));
                end
            end
            stall_prev = bus.o_valid && !bus.i_ready;
            snap_prev = {bus.o_valid, bus.o_is_hdr, bus.o_gcid_x, bus.o_gcid_y, bus.o_gcid_z,
                         bus.o_data, bus.o_last, bus.o_burst_cnt, bus.o_fold_err};
        end
    end

    // Queue the expected frame, then offer n records; optionally force a
    // 4-cycle downstream stall or abandon the burst after a given record.
    task automatic send_burst(input int unsigned fold, input int unsigned n,
                              input int unsigned stall_after, input int unsigned abort_after);
        beat_t       b;
        int unsigned t;
        bit          acc;
        logic [DW-1:0] recs [$];
        if (fold >= 2) err_model = 1'b1;
        b.hdr  = 1'b1;
        b.gcid = (fold < 2) ? {ref_x[fold], ref_y[fold], ref_z[fold]} : 9'd0;
        b.data = '0;
        b.last = 1'b0;
        b.cnt  = 0;
        b.err  = err_model;
        exp_q.push_back(b);
        for (int unsigned k = 0; k < n; k++) begin
            recs.push_back({$urandom, $urandom, $urandom});
            b.hdr  = 1'b0;
            b.data = recs[k];
            b.last = (k == n - 1);
            b.cnt  = (k + 1 > CNT_MAX) ? CNT_MAX : k + 1;
            exp_q.push_back(b);
        end
        bus.i_fold_id = fold[1:0];
        for (int unsigned k = 0; k < n; k++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = recs[k];
            bus.i_last  = (k == n - 1);
            t = 0;
            acc = 1'b0;
            while (!acc && t < 500) begin
                @(negedge clk);
                acc = bus.o_ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                check_eq("accept_timeout", 128'(0), 128'(1));
                bus.i_valid = 1'b0;
                return;
            end
            bus.i_fold_id = 2'($urandom);
            if (k + 1 == stall_after) stall_left = 4;
            if (k + 1 == abort_after) break;
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        check_eq("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #2_000_000;
        check_eq("watchdog", 128'(0), 128'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_valid   = 1'b0;
        bus.i_fold_id = '0;
        bus.i_data    = '0;
        bus.i_last    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_o_valid", 128'(bus.o_valid), 128'(0));
        check_eq("rst_o_ready", 128'(bus.o_ready), 128'(0));
        check_eq("rst_outputs", 128'({bus.o_is_hdr, bus.o_last, bus.o_gcid_x, bus.o_gcid_y,
                 bus.o_gcid_z, bus.o_data, bus.o_burst_cnt, bus.o_fold_err}), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        send_burst(1, 3, 0, 0);
        drain();
        send_burst(0, 1, 0, 0);
        drain();
        send_burst(1, 6, 2, 0);
        drain();
        send_burst(0, 2, 0, 0);
        send_burst(1, 2, 0, 0);
        drain();
        send_burst(3, 2, 0, 0);
        send_burst(0, 2, 0, 0);
        drain();
        send_burst(1, 260, 0, 0);
        drain();

        ready_pct = 70;
        for (int unsigned i = 0; i < 30; i++) begin
            send_burst($urandom_range(3), $urandom_range(6, 1),
                       ($urandom_range(3) == 0) ? 1 : 0, 0);
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end
        drain();

        ready_pct = 100;
        send_burst(0, 5, 0, 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_o_valid", 128'(bus.o_valid), 128'(0));
        check_eq("midrst_o_ready", 128'(bus.o_ready), 128'(0));
        check_eq("midrst_outputs", 128'({bus.o_is_hdr, bus.o_last, bus.o_gcid_x, bus.o_gcid_y,
                 bus.o_gcid_z, bus.o_data, bus.o_burst_cnt, bus.o_fold_err}), 128'(0));
        exp_q.delete();
        err_model = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_burst(1, 2, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
